// File: rtl/uart_pkg.sv
// Shared definitions for the framed UART receiver: parity modes, FSM states,
// parameter legality limits and a small majority-vote helper.
package uart_pkg;

    // Legal parameter ranges for the receiver and its word buffer.
    localparam int DATA_WIDTH_MIN = 5;
    localparam int DATA_WIDTH_MAX = 9;
    localparam int FIFO_DEPTH_MIN = 2;
    localparam int FIFO_DEPTH_MAX = 16;

    // Bit-timing counter width: 8 * 65535 fits without overflow.
    localparam int CNT_W = 19;

    // Parity mode encodings; mode 3 behaves exactly like none.
    localparam logic [1:0] PARITY_NONE     = 2'd0;
    localparam logic [1:0] PARITY_EVEN     = 2'd1;
    localparam logic [1:0] PARITY_ODD      = 2'd2;
    localparam logic [1:0] PARITY_NONE_ALT = 2'd3;

    // Receiver FSM states.
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        START      = 3'd1,
        DATA       = 3'd2,
        PARITY     = 3'd3,
        STOP       = 3'd4,
        BREAK_WAIT = 3'd5
    } rx_state_e;

    // 2-of-3 majority vote used to resolve each bit.
    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous word buffer for received frames. A write into a full buffer is
// ignored even if a read happens in the same cycle; the read port shows zero
// while empty so the downstream data bus idles at zero.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CW    = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CW-1:0]    count;
    logic             wr_ok;
    logic             rd_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign wr_ok   = wr_en && !full;
    assign rd_ok   = rd_en && !empty;
    assign rd_data = empty ? '0 : mem[rd_ptr];

    // Storage array; only written through an accepted push.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_framed.sv
// Oversampling UART receiver with runtime framing (5..DATA_WIDTH data bits,
// optional even/odd parity, one or two stop bits), break detection and an
// AXI-Stream style output buffer.
//
// Output handshake: a word transfers on a rising clk edge where m_axis_tvalid
// and m_axis_tready are both high; while tvalid is high and tready is low,
// tdata/tuser hold their value. tvalid never depends on tready.
module uart_rx_framed
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rxd,
    input  logic [15:0]           prescale,
    input  logic [3:0]            data_bits,
    input  logic [1:0]            parity_mode,
    input  logic                  stop_bits,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tuser,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  busy,
    output logic                  overrun_error,
    output logic                  frame_error,
    output logic                  parity_error,
    output logic                  break_detect,
    output rx_state_e             state_dbg
);
    localparam int FW = DATA_WIDTH + 1;

    logic                  rxd_meta;
    logic                  rxd_s;
    rx_state_e             state;
    rx_state_e             state_n;
    logic [CNT_W-1:0]      cnt;
    logic [CNT_W-1:0]      p_ext;
    logic [CNT_W-1:0]      t3;
    logic [CNT_W-1:0]      t4;
    logic [CNT_W-1:0]      t5;
    logic [CNT_W-1:0]      t_end;
    logic [15:0]           p_lat;
    logic [3:0]            nbits_lat;
    logic [3:0]            bit_idx;
    logic [1:0]            par_lat;
    logic                  stop2_lat;
    logic                  stop_idx;
    logic                  s3;
    logic                  s4;
    logic                  bit_val;
    logic                  at_s3;
    logic                  at_s4;
    logic                  at_s5;
    logic                  at_end;
    logic                  last_data;
    logic                  last_stop;
    logic                  par_on;
    logic                  any_one;
    logic                  stop_ok;
    logic                  par_acc;
    logic                  par_err;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  push_q;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [FW-1:0]         fifo_rd;

    // Sample points derived from the prescale latched at frame start.
    assign p_ext = {3'b000, p_lat};
    assign t4    = p_ext << 2;
    assign t3    = t4 - p_ext;
    assign t5    = t4 + p_ext;
    assign t_end = (p_ext << 3) - CNT_W'(1);

    assign at_s3  = (cnt == t3);
    assign at_s4  = (cnt == t4);
    assign at_s5  = (cnt == t5);
    assign at_end = (cnt == t_end);

    // Bit value resolved on the third sample, using the two stored ones.
    assign bit_val   = majority3(s3, s4, rxd_s);
    assign last_data = (bit_idx == nbits_lat - 4'd1);
    assign last_stop = !stop2_lat || stop_idx;
    assign par_on    = (par_lat == PARITY_EVEN) || (par_lat == PARITY_ODD);

    // Two-flop synchroniser; idles high so reset never looks like a start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxd_meta <= 1'b1;
            rxd_s    <= 1'b1;
        end else begin
            rxd_meta <= rxd;
            rxd_s    <= rxd_meta;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic: bits advance on the last clock of each 8P period,
    // except the final stop bit which decides the frame at its third sample.
    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (!rxd_s) begin
                    state_n = START;
                end
            end
            START: begin
                if (at_s5 && bit_val) begin
                    state_n = IDLE;
                end else if (at_end) begin
                    state_n = DATA;
                end
            end
            DATA: begin
                if (at_end && last_data) begin
                    state_n = par_on ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (at_end) begin
                    state_n = STOP;
                end
            end
            STOP: begin
                if (at_s5 && last_stop) begin
                    if ((stop_ok && bit_val) || any_one || bit_val) begin
                        state_n = IDLE;
                    end else begin
                        state_n = BREAK_WAIT;
                    end
                end
            end
            BREAK_WAIT: begin
                if (rxd_s && at_end) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Frame datapath: config latch, bit timing, sampling, word assembly and
    // the registered push/status pulses issued the cycle after the decision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt          <= '0;
            p_lat        <= 16'd1;
            nbits_lat    <= 4'(DATA_WIDTH);
            par_lat      <= PARITY_NONE;
            stop2_lat    <= 1'b0;
            stop_idx     <= 1'b0;
            bit_idx      <= '0;
            s3           <= 1'b1;
            s4           <= 1'b1;
            any_one      <= 1'b0;
            stop_ok      <= 1'b1;
            par_acc      <= 1'b0;
            par_err      <= 1'b0;
            data_q       <= '0;
            push_q       <= 1'b0;
            frame_error  <= 1'b0;
            parity_error <= 1'b0;
            break_detect <= 1'b0;
        end else begin
            push_q       <= 1'b0;
            frame_error  <= 1'b0;
            parity_error <= 1'b0;
            break_detect <= 1'b0;
            if (at_s3) begin
                s3 <= rxd_s;
            end
            if (at_s4) begin
                s4 <= rxd_s;
            end
            case (state)
                IDLE: begin
                    cnt <= CNT_W'(1);
                    if (!rxd_s) begin
                        p_lat     <= (prescale == 16'd0) ? 16'd1 : prescale;
                        nbits_lat <= ((data_bits < 4'd5) || (data_bits > 4'(DATA_WIDTH)))
                                     ? 4'(DATA_WIDTH) : data_bits;
                        par_lat   <= parity_mode;
                        stop2_lat <= stop_bits;
                        stop_idx  <= 1'b0;
                        bit_idx   <= '0;
                        any_one   <= 1'b0;
                        stop_ok   <= 1'b1;
                        par_acc   <= 1'b0;
                        par_err   <= 1'b0;
                        data_q    <= '0;
                    end
                end
                START: begin
                    cnt <= at_end ? '0 : cnt + CNT_W'(1);
                end
                DATA: begin
                    cnt <= at_end ? '0 : cnt + CNT_W'(1);
                    if (at_s5) begin
                        data_q  <= data_q | ({{(DATA_WIDTH-1){1'b0}}, bit_val} << bit_idx);
                        par_acc <= par_acc ^ bit_val;
                        any_one <= any_one | bit_val;
                    end
                    if (at_end) begin
                        bit_idx <= bit_idx + 4'd1;
                    end
                end
                PARITY: begin
                    cnt <= at_end ? '0 : cnt + CNT_W'(1);
                    if (at_s5) begin
                        any_one <= any_one | bit_val;
                        par_err <= (par_acc ^ bit_val) != (par_lat == PARITY_ODD);
                    end
                end
                STOP: begin
                    cnt <= at_end ? '0 : cnt + CNT_W'(1);
                    if (at_s5) begin
                        any_one <= any_one | bit_val;
                        stop_ok <= stop_ok & bit_val;
                        if (last_stop) begin
                            cnt <= '0;
                            if (stop_ok && bit_val) begin
                                push_q       <= 1'b1;
                                parity_error <= par_err;
                            end else if (any_one || bit_val) begin
                                frame_error <= 1'b1;
                            end else begin
                                break_detect <= 1'b1;
                            end
                        end
                    end
                    if (at_end) begin
                        stop_idx <= 1'b1;
                    end
                end
                BREAK_WAIT: begin
                    cnt <= rxd_s ? cnt + CNT_W'(1) : '0;
                end
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end

    uart_rx_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push_q),
        .wr_data ({par_err, data_q}),
        .rd_en   (m_axis_tready),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign m_axis_tdata  = fifo_rd[DATA_WIDTH-1:0];
    assign m_axis_tuser  = fifo_rd[DATA_WIDTH];
    assign m_axis_tvalid = !fifo_empty;
    assign overrun_error = push_q && fifo_full;
    assign busy          = (state != IDLE);
    assign state_dbg     = state;

endmodule

// File: tb/tb_uart_rx_framed.sv
// Directed bench for uart_rx_framed: frames are driven bit by bit on the
// falling clock edge, outputs are sampled on the falling edge as well.
module tb_uart_rx_framed;
    import uart_pkg::*;

    localparam int DW = 8;
    localparam int FD = 4;

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rxd = 1'b1;
    logic [15:0]   prescale = 16'd2;
    logic [3:0]    data_bits = 4'd8;
    logic [1:0]    parity_mode = 2'd0;
    logic          stop_bits = 1'b0;
    logic          m_axis_tready = 1'b0;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tuser;
    logic          m_axis_tvalid;
    logic          busy;
    logic          overrun_error;
    logic          frame_error;
    logic          parity_error;
    logic          break_detect;
    rx_state_e     state_dbg;

    always #5 clk = ~clk;

    uart_rx_framed #(.DATA_WIDTH(DW), .FIFO_DEPTH(FD)) dut (
        .clk           (clk),
        .rst           (rst),
        .rxd           (rxd),
        .prescale      (prescale),
        .data_bits     (data_bits),
        .parity_mode   (parity_mode),
        .stop_bits     (stop_bits),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .busy          (busy),
        .overrun_error (overrun_error),
        .frame_error   (frame_error),
        .parity_error  (parity_error),
        .break_detect  (break_detect),
        .state_dbg     (state_dbg)
    );

    // ---------------- scoreboard state ----------------
    int          n_vec = 0;
    int          n_err = 0;
    int          n_fe = 0;
    int          n_pe = 0;
    int          n_ov = 0;
    int          n_bd = 0;
    logic [DW:0] got_q[$];
    logic [DW:0] exp_q[$];

    // Output monitor: accepted words and status pulse counts.
    always @(negedge clk) begin
        if (!rst) begin
            if (m_axis_tvalid && m_axis_tready) got_q.push_back({m_axis_tuser, m_axis_tdata});
            if (frame_error)   n_fe++;
            if (parity_error)  n_pe++;
            if (overrun_error) n_ov++;
            if (break_detect)  n_bd++;
        end
    end

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: got timeout, required summary before 60000 cycles");
        $fatal(1);
    end

    // ---------------- driver tasks ----------------
    task automatic set_cfg(input int p, input int db, input int pm, input int sb);
        prescale    = 16'(p);
        data_bits   = 4'(db);
        parity_mode = 2'(pm);
        stop_bits   = 1'(sb);
    endtask

    task automatic hold_bit(input logic v, input int p);
        rxd = v;
        repeat (8 * p) @(negedge clk);
    endtask

    task automatic send_frame(input int p, input int nb, input logic [8:0] data,
                              input logic has_par, input logic par_bit,
                              input int nstop, input logic stop_val);
        hold_bit(1'b0, p);
        for (int i = 0; i < nb; i++) hold_bit(data[i], p);
        if (has_par) hold_bit(par_bit, p);
        for (int i = 0; i < nstop; i++) hold_bit(stop_val, p);
        rxd = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_vec++; if (m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL reset_tvalid got %b want 0", m_axis_tvalid); end
        n_vec++; if (m_axis_tdata !== 8'h00) begin n_err++; $display("FAIL reset_tdata got %h want 00", m_axis_tdata); end
        n_vec++; if (m_axis_tuser !== 1'b0) begin n_err++; $display("FAIL reset_tuser got %b want 0", m_axis_tuser); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
        n_vec++; if ({overrun_error, frame_error, parity_error, break_detect} !== 4'b0000) begin
            n_err++; $display("FAIL reset_pulses got %b want 0000", {overrun_error, frame_error, parity_error, break_detect});
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++; if (state_dbg !== IDLE) begin n_err++; $display("FAIL reset_state got %0d want %0d", state_dbg, IDLE); end
    endtask

    task automatic test_basic();
        int base = got_q.size();
        int fe0 = n_fe, pe0 = n_pe, ov0 = n_ov, bd0 = n_bd;
        int lat = 0;
        logic [DW:0] w = 'x;
        set_cfg(2, 8, 0, 0);
        m_axis_tready = 1'b1;
        exp_q.push_back(9'h0A5);
        fork
            send_frame(2, 8, 9'h0A5, 1'b0, 1'b0, 1, 1'b1);
            begin
                while (!m_axis_tvalid && lat < 200) begin @(negedge clk); lat++; end
            end
        join
        hold_bit(1'b1, 2);
        n_vec++; if (lat > 163) begin n_err++; $display("FAIL basic_latency got %0d want <=163", lat); end
        n_vec++; if (got_q.size() != base + 1) begin n_err++; $display("FAIL basic_count got %0d want 1", got_q.size() - base); end
        if (got_q.size() > base) w = got_q[base];
        n_vec++; if (w !== exp_q[0]) begin n_err++; $display("FAIL basic_word got %h want %h", w, exp_q[0]); end
        void'(exp_q.pop_front());
        n_vec++; if ((n_fe - fe0) + (n_pe - pe0) + (n_ov - ov0) + (n_bd - bd0) != 0) begin
            n_err++; $display("FAIL basic_pulses got %0d want 0", (n_fe - fe0) + (n_pe - pe0) + (n_ov - ov0) + (n_bd - bd0));
        end
    endtask

    task automatic test_parity();
        int base = got_q.size();
        int pe0 = n_pe, fe0 = n_fe;
        logic [DW:0] w = 'x;
        // 0x41 has two ones: even parity bit is 0, drive 1 (wrong).
        set_cfg(4, 7, 1, 1);
        exp_q.push_back(9'h141);
        send_frame(4, 7, 9'h041, 1'b1, 1'b1, 2, 1'b1);
        hold_bit(1'b1, 4);
        n_vec++; if (n_pe - pe0 != 1) begin n_err++; $display("FAIL parity_even_pulse got %0d want 1", n_pe - pe0); end
        if (got_q.size() > base) w = got_q[base];
        n_vec++; if (w !== exp_q[0]) begin n_err++; $display("FAIL parity_even_word got %h want %h", w, exp_q[0]); end
        void'(exp_q.pop_front());
        // Odd mode with the correct parity bit 1 must be clean.
        set_cfg(4, 7, 2, 1);
        exp_q.push_back(9'h041);
        w = 'x;
        send_frame(4, 7, 9'h041, 1'b1, 1'b1, 2, 1'b1);
        hold_bit(1'b1, 4);
        if (got_q.size() > base + 1) w = got_q[base + 1];
        n_vec++; if (w !== exp_q[0]) begin n_err++; $display("FAIL parity_odd_word got %h want %h", w, exp_q[0]); end
        void'(exp_q.pop_front());
        n_vec++; if (n_pe - pe0 != 1) begin n_err++; $display("FAIL parity_odd_pulse got %0d want 1 total", n_pe - pe0); end
        n_vec++; if (n_fe != fe0) begin n_err++; $display("FAIL parity_fe got %0d want 0", n_fe - fe0); end
    endtask

    task automatic test_clamp();
        int base = got_q.size();
        logic [DW:0] w;
        // data_bits 3 is out of range and clamps to 8.
        set_cfg(2, 3, 0, 0);
        exp_q.push_back(9'h081);
        send_frame(2, 8, 9'h081, 1'b0, 1'b0, 1, 1'b1);
        hold_bit(1'b1, 2);
        // Minimum 5 data bits.
        set_cfg(2, 5, 0, 0);
        exp_q.push_back(9'h015);
        send_frame(2, 5, 9'h015, 1'b0, 1'b0, 1, 1'b1);
        hold_bit(1'b1, 2);
        // Prescale 0 runs as prescale 1; parity mode 3 runs as none.
        set_cfg(0, 8, 3, 0);
        exp_q.push_back(9'h0C3);
        send_frame(1, 8, 9'h0C3, 1'b0, 1'b0, 1, 1'b1);
        hold_bit(1'b1, 2);
        for (int i = 0; i < 3; i++) begin
            w = 'x;
            if (got_q.size() > base + i) w = got_q[base + i];
            n_vec++; if (w !== exp_q[0]) begin n_err++; $display("FAIL clamp_word%0d got %h want %h", i, w, exp_q[0]); end
            void'(exp_q.pop_front());
        end
    endtask

    task automatic test_frame_break();
        int base = got_q.size();
        int fe0 = n_fe, bd0 = n_bd;
        set_cfg(2, 8, 0, 0);
        send_frame(2, 8, 9'h03C, 1'b0, 1'b0, 1, 1'b0);
        hold_bit(1'b1, 2);
        hold_bit(1'b1, 2);
        n_vec++; if (n_fe - fe0 != 1) begin n_err++; $display("FAIL frame_err_pulse got %0d want 1", n_fe - fe0); end
        n_vec++; if (got_q.size() != base) begin n_err++; $display("FAIL frame_err_word got %0d words want 0", got_q.size() - base); end
        n_vec++; if (n_bd != bd0) begin n_err++; $display("FAIL frame_err_bd got %0d want 0", n_bd - bd0); end
        // Line low for 12 bit times.
        rxd = 1'b0;
        repeat (12 * 16) @(negedge clk);
        n_vec++; if (n_bd - bd0 != 1) begin n_err++; $display("FAIL break_pulse got %0d want 1", n_bd - bd0); end
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL break_busy_low got %b want 1", busy); end
        rxd = 1'b1;
        repeat (10) @(negedge clk);
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL break_busy_rel10 got %b want 1", busy); end
        repeat (14) @(negedge clk);
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL break_busy_rel24 got %b want 0", busy); end
        n_vec++; if (n_fe - fe0 != 1 || got_q.size() != base) begin
            n_err++; $display("FAIL break_extra got fe %0d words %0d want 1 and 0", n_fe - fe0, got_q.size() - base);
        end
    endtask

    task automatic test_overrun();
        int base = got_q.size();
        int ov0 = n_ov;
        logic [DW:0] w;
        set_cfg(2, 8, 0, 0);
        m_axis_tready = 1'b0;
        for (int v = 1; v <= 5; v++) begin
            send_frame(2, 8, 9'(v), 1'b0, 1'b0, 1, 1'b1);
            hold_bit(1'b1, 2);
            if (v == 1) begin
                n_vec++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 8'h01) begin
                    n_err++; $display("FAIL ovr_first got v=%b d=%h want v=1 d=01", m_axis_tvalid, m_axis_tdata);
                end
            end
        end
        n_vec++; if (n_ov - ov0 != 1) begin n_err++; $display("FAIL ovr_pulse got %0d want 1", n_ov - ov0); end
        n_vec++; if (m_axis_tdata !== 8'h01) begin n_err++; $display("FAIL ovr_stable got %h want 01", m_axis_tdata); end
        for (int v = 1; v <= 4; v++) exp_q.push_back(9'(v));
        m_axis_tready = 1'b1;
        repeat (10) @(negedge clk);
        n_vec++; if (got_q.size() != base + 4) begin n_err++; $display("FAIL ovr_count got %0d want 4", got_q.size() - base); end
        for (int i = 0; i < 4; i++) begin
            w = 'x;
            if (got_q.size() > base + i) w = got_q[base + i];
            n_vec++; if (w !== exp_q[0]) begin n_err++; $display("FAIL ovr_drain%0d got %h want %h", i, w, exp_q[0]); end
            void'(exp_q.pop_front());
        end
    endtask

    task automatic test_glitch();
        int base = got_q.size();
        int tot0 = n_fe + n_pe + n_ov + n_bd;
        set_cfg(4, 8, 0, 0);
        rxd = 1'b0;
        repeat (3) @(negedge clk);
        rxd = 1'b1;
        repeat (5) @(negedge clk);
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL glitch_seen got busy %b want 1", busy); end
        repeat (60) @(negedge clk);
        n_vec++; if (state_dbg !== IDLE || busy !== 1'b0) begin
            n_err++; $display("FAIL glitch_idle got state %0d busy %b want %0d 0", state_dbg, busy, IDLE);
        end
        n_vec++; if (got_q.size() != base || n_fe + n_pe + n_ov + n_bd != tot0) begin
            n_err++; $display("FAIL glitch_quiet got words %0d pulses %0d want 0 0", got_q.size() - base, n_fe + n_pe + n_ov + n_bd - tot0);
        end
    endtask

    task automatic test_reset_mid();
        int base;
        int tot0;
        logic [DW:0] w = 'x;
        set_cfg(2, 8, 0, 0);
        m_axis_tready = 1'b1;
        fork
            send_frame(2, 8, 9'h0FF, 1'b0, 1'b0, 1, 1'b1);
            begin
                repeat (50) @(negedge clk);
                n_vec++; if (state_dbg !== DATA) begin n_err++; $display("FAIL rstmid_pre got %0d want %0d", state_dbg, DATA); end
                rst = 1'b1;
                repeat (2) @(negedge clk);
                n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy got %b want 0", busy); end
                rst = 1'b0;
            end
        join
        base = got_q.size();
        tot0 = n_fe + n_pe + n_ov + n_bd;
        hold_bit(1'b1, 2);
        n_vec++; if (got_q.size() != base || n_fe + n_pe + n_ov + n_bd != tot0) begin
            n_err++; $display("FAIL rstmid_quiet got words %0d pulses %0d want 0 0", got_q.size() - base, n_fe + n_pe + n_ov + n_bd - tot0);
        end
        exp_q.push_back(9'h05A);
        send_frame(2, 8, 9'h05A, 1'b0, 1'b0, 1, 1'b1);
        hold_bit(1'b1, 2);
        if (got_q.size() > base) w = got_q[base];
        n_vec++; if (w !== exp_q[0]) begin n_err++; $display("FAIL rstmid_next got %h want %h", w, exp_q[0]); end
        void'(exp_q.pop_front());
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_parity();
        test_clamp();
        test_frame_break();
        test_overrun();
        test_glitch();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
